// File: rtl/sinc_stepper.sv
// Signed step counter: adds/subtracts a programmable step each RUN cycle, stops at an optional limit,
// wraps or saturates on overflow. Define SINC_STEPPER_STICKY_OVF_EN to make ovf sticky.
module sinc_stepper #(
    parameter int DATAWIDTH = 8,
    parameter int STEPWIDTH = 4,
    parameter bit SATURATE  = 1'b0
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 load,
    input  logic [DATAWIDTH-1:0] ld_val,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 up,
    input  logic [STEPWIDTH-1:0] step,
    input  logic                 lim_en,
    input  logic [DATAWIDTH-1:0] limit,
    output logic [DATAWIDTH-1:0] d,
    output logic                 busy,
    output logic                 done,
    output logic                 ovf
);

    localparam int XW = DATAWIDTH + 2;

`ifdef SINC_STEPPER_STICKY_OVF_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [DATAWIDTH-1:0]   d_q, d_d;
    logic                   ovf_q, ovf_d;

    logic signed [XW-1:0]   d_ext, step_ext, lim_ext, nxt;
    logic signed [XW-1:0]   max_ext, min_ext;
    logic                   lim_hit, ovf_hit;
    logic [DATAWIDTH-1:0]   sat_val;

    // Widened by two bits so neither the sum nor the limit comparison can itself overflow.
    assign d_ext    = {{2{d_q[DATAWIDTH-1]}}, d_q};
    assign lim_ext  = {{2{limit[DATAWIDTH-1]}}, limit};
    assign step_ext = {{(XW-STEPWIDTH){1'b0}}, step};
    assign max_ext  = {3'b000, {(DATAWIDTH-1){1'b1}}};
    assign min_ext  = {3'b111, {(DATAWIDTH-1){1'b0}}};
    assign nxt      = up ? (d_ext + step_ext) : (d_ext - step_ext);
    assign sat_val  = up ? max_ext[DATAWIDTH-1:0] : min_ext[DATAWIDTH-1:0];
    assign ovf_hit  = (nxt > max_ext) || (nxt < min_ext);

    // A zero step only terminates on an exact match, otherwise the count simply holds.
    always_comb begin
        lim_hit = 1'b0;
        if (lim_en) begin
            if (step == '0)
                lim_hit = (d_q == limit);
            else if (up)
                lim_hit = (nxt >= lim_ext);
            else
                lim_hit = (nxt <= lim_ext);
        end
    end

    always_comb begin
        state_d = state_q;
        d_d     = d_q;
        ovf_d   = STICKY ? ovf_q : 1'b0;
        if (load) begin
            d_d     = ld_val;
            state_d = S_IDLE;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                S_RUN: begin
                    if (stop) begin
                        state_d = S_IDLE;
                    end else if (lim_hit) begin
                        d_d     = limit;
                        state_d = S_DONE;
                    end else if (ovf_hit) begin
                        d_d   = SATURATE ? sat_val : nxt[DATAWIDTH-1:0];
                        ovf_d = 1'b1;
                    end else begin
                        d_d = nxt[DATAWIDTH-1:0];
                    end
                end
                S_IDLE, S_DONE: begin
                    if (!stop && start) begin
                        state_d = S_RUN;
                        ovf_d   = 1'b0;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= S_IDLE;
            d_q     <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            d_q     <= d_d;
            ovf_q   <= ovf_d;
        end
    end

    assign d    = d_q;
    assign busy = (state_q == S_RUN);
    assign done = (state_q == S_DONE);
    assign ovf  = ovf_q;

endmodule
